exec_writeback: RTL and testbench
=================================

Name: exec_writeback

Overview:
- Execute-stage writeback block, directly downstream of the ALU.
- Buffers ALU results and status flags in a small in-order queue, then retires one entry per commit handshake.
- On retirement it writes the result to the register file unless the op is no-write, and updates the architectural flags (CF/PF/ZF/SF/OF).
- Drives the ALU's status input with forwarded flags: the youngest pending flag-writing entry, else the architectural flags.

Parameters:
- DEPTH, 2, queue entries; power of two, ≥2.
- DATA_W, 32, result width.
- REG_AW, 3, register-file address width (8 GPRs).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  queue can accept (not full)
- in_result  in  DATA_W  ALU result
- in_status  in  5  ALU status; 4:CF 3:PF 2:ZF 1:SF 0:OF
- in_dest  in  REG_AW  destination register
- in_no_wr  in  1  suppress register write (ALU_NO_WR, e.g. CMP/TEST)
- in_flags_wr  in  1  op updates flags
- flush  in  1  drop all pending entries
- commit_valid  out  1  head entry available
- commit_ready  in  1  consumer accepts head
- commit_result  out  DATA_W  head result
- commit_dest  out  REG_AW  head destination
- rf_wr_en  out  1  register-file write strobe
- rf_wr_addr  out  REG_AW  write address
- rf_wr_data  out  DATA_W  write data
- flags_q  out  5  architectural flags
- status_fwd  out  5  flags for the ALU status_in

Behaviour:
- Reset (async, rst_n=0):
  - Queue empty; rd_ptr=wr_ptr=0; count=0.
  - flags_q=5'b0.
  - commit_valid=0, in_ready=1, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0.
  - Reset mid-operation discards all entries; no write occurs.
- Enqueue: fires when in_valid & in_ready. Entry stores {result, status, dest, no_wr, flags_wr} at wr_ptr; wr_ptr wraps modulo DEPTH.
- in_ready = (count != DEPTH). It is combinational on count only and does not depend on a same-cycle dequeue, so a full queue accepts no input even if commit fires.
- commit_valid = (count != 0). commit_result and commit_dest show the head entry combinationally. Minimum latency from enqueue to commit_valid is 1 cycle.
- Dequeue: fires when commit_valid & commit_ready.
  - rd_ptr advances, wrapping modulo DEPTH.
  - Next cycle, rf_wr_en = ~head.no_wr, with rf_wr_addr/rf_wr_data registered from the head. Registered write port, 1-cycle delay.
  - If head.flags_wr, flags_q <= head.status at the same edge as the dequeue.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- flush=1:
  - At the next edge, count=0 and rd_ptr=wr_ptr=0.
  - A same-cycle enqueue is dropped and a same-cycle dequeue is ignored: no flag update, and rf_wr_en=0 next cycle.
  - flags_q is unchanged.
- status_fwd (combinational): status of the youngest queued entry with flags_wr=1; if none, flags_q. Entries being enqueued this cycle are not included. A dequeue this cycle does not change status_fwd until the edge.
- rf_wr_en is a single-cycle pulse per qualifying commit and otherwise 0. rf_wr_addr/rf_wr_data hold their last value when rf_wr_en=0.
- commit_valid holds, with stable data, while commit_ready=0. Upstream must hold in_* stable while in_valid & ~in_ready.
- X-free outputs after reset. Entry storage does not need a reset; only pointers, count, flags_q and the rf_* registers do.

Test Plan:
- Single op: enqueue result=0x0000_0005, dest=3, status=5'b00000, no_wr=0, flags_wr=1 with commit_ready=1.
  - commit_valid=1 the cycle after enqueue and dequeue fires.
  - Next cycle: rf_wr_en=1, addr=3, data=5, flags_q=0.
- CMP-style op: no_wr=1, flags_wr=1, status=5'b00100 (ZF).
  - Commit leaves rf_wr_en=0 and sets flags_q=5'b00100.
- Back-pressure: commit_ready=0, enqueue 3 ops.
  - in_ready drops after 2 accepts; the third is held.
  - Releasing commit_ready retires all three in order on consecutive cycles; the 3rd result appears on rf_wr_data after the first two.
- Forwarding: flags_q=0; queue entry A (flags_wr=1, status=5'b10000) then B (flags_wr=0).
  - status_fwd=5'b10000.
  - After both commit, flags_q=5'b10000 and status_fwd=5'b10000.
- Flush with 2 entries pending plus a same-cycle commit and enqueue.
  - Next cycle: commit_valid=0, in_ready=1, rf_wr_en=0, flags_q unchanged.
- Async reset asserted mid-cycle while full: outputs go to reset values immediately, without waiting for a clock edge. After release the queue is empty.

Source files
------------

// File: rtl/exec_writeback.sv
// exec_writeback: execute-stage writeback queue sitting directly behind the ALU.
// Holds ALU results and status flags in order and retires one entry per
// commit handshake. On retirement it writes the register file through a
// registered port and updates the architectural flags. It also forwards the
// youngest pending flag value back to the ALU.
module exec_writeback #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [4:0]        in_status,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              in_no_wr,
    input  logic              in_flags_wr,
    input  logic              flush,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [DATA_W-1:0] commit_result,
    output logic [REG_AW-1:0] commit_dest,
    output logic              rf_wr_en,
    output logic [REG_AW-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic [4:0]        flags_q,
    output logic [4:0]        status_fwd
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    // Entry storage; deliberately not reset, since only entries below count are ever observed.
    logic [DATA_W-1:0] result_mem   [DEPTH];
    logic [4:0]        status_mem   [DEPTH];
    logic [REG_AW-1:0] dest_mem     [DEPTH];
    logic              no_wr_mem    [DEPTH];
    logic              flags_wr_mem [DEPTH];

    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [4:0]        flags_d;
    logic              rf_wr_en_q, rf_wr_en_d;
    logic [REG_AW-1:0] rf_wr_addr_q;
    logic [DATA_W-1:0] rf_wr_data_q;
    logic [4:0]        fwd_d;

    logic enq_fire;
    logic deq_fire;
    logic retire;

    // Handshakes are qualified so that a flush cancels both the enqueue and the dequeue.
    assign in_ready     = (count_q != DEPTH_C);
    assign commit_valid = (count_q != '0);
    assign enq_fire     = in_valid & in_ready & ~flush;
    assign deq_fire     = commit_valid & commit_ready;
    assign retire       = deq_fire & ~flush;

    // Head is gated with commit_valid so the outputs stay defined while the queue is empty.
    assign commit_result = commit_valid ? result_mem[rd_ptr_q] : '0;
    assign commit_dest   = commit_valid ? dest_mem[rd_ptr_q]   : '0;

    assign rf_wr_en   = rf_wr_en_q;
    assign rf_wr_addr = rf_wr_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign status_fwd = fwd_d;

    // Write the incoming ALU result into the tail slot.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            result_mem[wr_ptr_q]   <= in_result;
            status_mem[wr_ptr_q]   <= in_status;
            dest_mem[wr_ptr_q]     <= in_dest;
            no_wr_mem[wr_ptr_q]    <= in_no_wr;
            flags_wr_mem[wr_ptr_q] <= in_flags_wr;
        end
    end

    // Next-state for pointers, count, flags and the registered write port.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        flags_d    = flags_q;
        rf_wr_en_d = 1'b0;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointer width equals log2(DEPTH), so the increment wraps naturally.
            if (enq_fire) wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq_fire) rd_ptr_d = rd_ptr_q + 1'b1;
            if (enq_fire && !deq_fire) count_d = count_q + 1'b1;
            else if (!enq_fire && deq_fire) count_d = count_q - 1'b1;
            if (retire && flags_wr_mem[rd_ptr_q]) flags_d = status_mem[rd_ptr_q];
            rf_wr_en_d = retire & ~no_wr_mem[rd_ptr_q];
        end
    end

    // Queue control and architectural flag state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
        end
    end

    // Registered register-file write port; address and data hold between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
        end else begin
            rf_wr_en_q <= rf_wr_en_d;
            if (rf_wr_en_d) begin
                rf_wr_addr_q <= dest_mem[rd_ptr_q];
                rf_wr_data_q <= result_mem[rd_ptr_q];
            end
        end
    end

    // Scan oldest to youngest so the last flag-writing match is the youngest one.
    always_comb begin
        logic [AW-1:0] idx;
        idx   = '0;
        fwd_d = flags_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + AW'(i);
            if (((AW + 1)'(i) < count_q) && flags_wr_mem[idx]) fwd_d = status_mem[idx];
        end
    end

endmodule

// File: tb/tb_exec_writeback.sv
// Directed testbench for exec_writeback: single op, CMP-style op, back-pressure,
// flag forwarding, flush and asynchronous reset.
module tb_exec_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [4:0]  in_status;
    logic [2:0]  in_dest;
    logic        in_no_wr;
    logic        in_flags_wr;
    logic        flush;
    logic        commit_valid;
    logic        commit_ready;
    logic [31:0] commit_result;
    logic [2:0]  commit_dest;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic [4:0]  flags_q;
    logic [4:0]  status_fwd;

    int n_checks = 0;
    int n_fail   = 0;

    exec_writeback #(.DEPTH(2), .DATA_W(32), .REG_AW(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_status    (in_status),
        .in_dest      (in_dest),
        .in_no_wr     (in_no_wr),
        .in_flags_wr  (in_flags_wr),
        .flush        (flush),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_result(commit_result),
        .commit_dest  (commit_dest),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .flags_q      (flags_q),
        .status_fwd   (status_fwd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge, then let combinational logic settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] st,
                         input logic [2:0] dst, input logic nw, input logic fw);
        in_valid    = v;
        in_result   = res;
        in_status   = st;
        in_dest     = dst;
        in_no_wr    = nw;
        in_flags_wr = fw;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        commit_ready = 1'b0;
        drive(1'b0, 32'h0, 5'b0, 3'd0, 1'b0, 1'b0);
        tick();
        tick();
        check("rst commit_valid", commit_valid, 0);
        check("rst in_ready", in_ready, 1);
        check("rst rf_wr_en", rf_wr_en, 0);
        check("rst rf_wr_addr", rf_wr_addr, 0);
        check("rst rf_wr_data", rf_wr_data, 0);
        check("rst flags_q", flags_q, 0);
        check("rst status_fwd", status_fwd, 0);
        rst_n = 1'b1;
        tick();

        // Single op
        commit_ready = 1'b1;
        drive(1'b1, 32'h5, 5'b00000, 3'd3, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 5'b0, 3'd0, 1'b0, 1'b0);
        check("single commit_valid", commit_valid, 1);
        check("single commit_result", commit_result, 32'h5);
        check("single commit_dest", commit_dest, 3);
        tick();
        check("single rf_wr_en", rf_wr_en, 1);
        check("single rf_wr_addr", rf_wr_addr, 3);
        check("single rf_wr_data", rf_wr_data, 32'h5);
        check("single flags_q", flags_q, 0);
        check("single empty", commit_valid, 0);
        tick();
        check("single pulse end", rf_wr_en, 0);
        check("single data hold", rf_wr_data, 32'h5);

        // CMP-style op
        drive(1'b1, 32'h99, 5'b00100, 3'd1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 5'b0, 3'd0, 1'b0, 1'b0);
        tick();
        check("cmp rf_wr_en", rf_wr_en, 0);
        check("cmp flags_q", flags_q, 5'b00100);
        check("cmp data hold", rf_wr_data, 32'h5);

        // Back-pressure
        commit_ready = 1'b0;
        drive(1'b1, 32'h11, 5'b0, 3'd2, 1'b0, 1'b0);
        check("bp ready A", in_ready, 1);
        tick();
        drive(1'b1, 32'h22, 5'b0, 3'd4, 1'b0, 1'b0);
        check("bp ready B", in_ready, 1);
        tick();
        drive(1'b1, 32'h33, 5'b0, 3'd5, 1'b0, 1'b0);
        check("bp full", in_ready, 0);
        tick();
        check("bp held full", in_ready, 0);
        check("bp head A", commit_result, 32'h11);
        commit_ready = 1'b1;
        tick();
        check("bp rf A en", rf_wr_en, 1);
        check("bp rf A data", rf_wr_data, 32'h11);
        check("bp rf A addr", rf_wr_addr, 2);
        check("bp head B", commit_result, 32'h22);
        tick();
        drive(1'b0, 32'h0, 5'b0, 3'd0, 1'b0, 1'b0);
        check("bp rf B en", rf_wr_en, 1);
        check("bp rf B data", rf_wr_data, 32'h22);
        check("bp head C", commit_result, 32'h33);
        tick();
        check("bp rf C en", rf_wr_en, 1);
        check("bp rf C data", rf_wr_data, 32'h33);
        check("bp rf C addr", rf_wr_addr, 5);
        tick();
        check("bp drained", commit_valid, 0);
        check("bp idle wr", rf_wr_en, 0);
        check("bp flags kept", flags_q, 5'b00100);

        // Forwarding: first clear flags_q with a flag-only op
        drive(1'b1, 32'h0, 5'b00000, 3'd0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 5'b0, 3'd0, 1'b0, 1'b0);
        tick();
        check("fwd flags clear", flags_q, 0);
        commit_ready = 1'b0;
        drive(1'b1, 32'hA, 5'b10000, 3'd1, 1'b0, 1'b1);
        check("fwd not yet queued", status_fwd, 0);
        tick();
        drive(1'b1, 32'hB, 5'b01111, 3'd2, 1'b0, 1'b0);
        check("fwd A pending", status_fwd, 5'b10000);
        tick();
        drive(1'b0, 32'h0, 5'b0, 3'd0, 1'b0, 1'b0);
        check("fwd A+B pending", status_fwd, 5'b10000);
        check("fwd arch flags", flags_q, 0);
        commit_ready = 1'b1;
        tick();
        check("fwd A retired", flags_q, 5'b10000);
        tick();
        check("fwd B flags_q", flags_q, 5'b10000);
        check("fwd B status_fwd", status_fwd, 5'b10000);
        check("fwd empty", commit_valid, 0);

        // Flush with a full queue and a same-cycle commit
        commit_ready = 1'b0;
        drive(1'b1, 32'h44, 5'b00010, 3'd3, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h55, 5'b00001, 3'd4, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h66, 5'b00111, 3'd5, 1'b0, 1'b1);
        check("flush youngest fwd", status_fwd, 5'b00001);
        flush = 1'b1;
        commit_ready = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'b0, 3'd0, 1'b0, 1'b0);
        check("flush commit_valid", commit_valid, 0);
        check("flush in_ready", in_ready, 1);
        check("flush rf_wr_en", rf_wr_en, 0);
        check("flush flags_q", flags_q, 5'b10000);
        check("flush status_fwd", status_fwd, 5'b10000);

        // Flush with one entry, a same-cycle commit and an accepted-looking enqueue
        commit_ready = 1'b0;
        drive(1'b1, 32'h88, 5'b00011, 3'd6, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h99, 5'b01100, 3'd7, 1'b0, 1'b1);
        check("flush2 ready", in_ready, 1);
        flush = 1'b1;
        commit_ready = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'b0, 3'd0, 1'b0, 1'b0);
        check("flush2 commit_valid", commit_valid, 0);
        check("flush2 rf_wr_en", rf_wr_en, 0);
        check("flush2 flags_q", flags_q, 5'b10000);
        tick();
        check("flush2 enq dropped", commit_valid, 0);

        // Queue still works after flush
        drive(1'b1, 32'h77, 5'b0, 3'd6, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 5'b0, 3'd0, 1'b0, 1'b0);
        check("post flush head", commit_result, 32'h77);
        tick();
        check("post flush rf data", rf_wr_data, 32'h77);
        check("post flush rf addr", rf_wr_addr, 6);

        // Asynchronous reset while full
        commit_ready = 1'b0;
        drive(1'b1, 32'hC1, 5'b11111, 3'd1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'hC2, 5'b11111, 3'd2, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 5'b0, 3'd0, 1'b0, 1'b0);
        check("ar full", in_ready, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar commit_valid", commit_valid, 0);
        check("ar in_ready", in_ready, 1);
        check("ar flags_q", flags_q, 0);
        check("ar status_fwd", status_fwd, 0);
        check("ar rf_wr_en", rf_wr_en, 0);
        check("ar rf_wr_addr", rf_wr_addr, 0);
        check("ar rf_wr_data", rf_wr_data, 0);
        #1;
        rst_n = 1'b1;
        tick();
        check("ar after empty", commit_valid, 0);
        check("ar after ready", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
